// File: rtl/x4xx_pps_pkg.sv
// x4xx_pps_pkg: shared PPS commit FSM encoding and default PPS timing constants
package x4xx_pps_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ARMED = 2'd1, ST_COMMIT = 2'd2} pps_state_t;
  localparam int DEF_NOMINAL_PERIOD = 250_000_000;
  localparam int DEF_PERIOD_TOL = 1024;
endpackage

// File: rtl/x4xx_pps_period_meter.sv
// x4xx_pps_period_meter: PPS period counter, valid flag and optional missing/out-of-tolerance check (X4XX_PPS_PERIOD_CHECK_EN)
//   clk_i, rst_n_i : clock, async active-low reset
//   pps_i          : one-cycle PPS pulse
//   missing_clr_i  : clear sticky missing flag
//   period_o, period_valid_o, missing_o : measured period, >=2 PPS seen, sticky missing/bad period
module x4xx_pps_period_meter
  import x4xx_pps_pkg::*;
#(
  parameter int PERIOD_W       = 32,
  parameter int NOMINAL_PERIOD = DEF_NOMINAL_PERIOD,
  parameter int PERIOD_TOL     = DEF_PERIOD_TOL
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                pps_i,
  input  logic                missing_clr_i,
  output logic [PERIOD_W-1:0] period_o,
  output logic                period_valid_o,
  output logic                missing_o
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d, period_q, meas;
  logic first_q, valid_q;
  always_comb begin
    meas  = cnt_q + 1'b1;
    cnt_d = pps_i ? '0 : (&cnt_q) ? cnt_q : meas;
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt_q    <= '0;
      period_q <= '0;
      first_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_q | pps_i;
      if (pps_i && first_q) begin
        period_q <= meas;
        valid_q  <= 1'b1;
      end
    end
  assign period_o       = period_q;
  assign period_valid_o = valid_q;
`ifdef X4XX_PPS_PERIOD_CHECK_EN
  localparam logic [PERIOD_W-1:0] LO = PERIOD_W'(NOMINAL_PERIOD - PERIOD_TOL);
  localparam logic [PERIOD_W-1:0] HI = PERIOD_W'(NOMINAL_PERIOD + PERIOD_TOL);
  logic missing_q, set_miss;
  // equality on the timeout limit makes the absent-PPS set fire exactly once
  assign set_miss = first_q && ((pps_i && (meas < LO || meas > HI)) || cnt_q == HI);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) missing_q <= 1'b0;
    else          missing_q <= set_miss | (missing_q & ~missing_clr_i);
  assign missing_o = missing_q;
`else
  logic unused_clr;
  assign unused_clr = missing_clr_i;
  assign missing_o  = 1'b0;
`endif
endmodule

// File: rtl/x4xx_pps_timekeeper.sv
// x4xx_pps_timekeeper: radio-domain 64-bit timekeeper with set-now / set-at-next-PPS, PPS time latch and period monitor
//   inputs : radio_clk, radio_rst_n (async active-low), pps_rc, time_strobe, set_time_value,
//            set_time_now, set_time_pps, set_cancel, pps_missing_clr
//   outputs: time_now, time_last_pps, pps_armed, pps_set_done, pps_period, pps_period_valid, pps_missing
//   X4XX_PPS_PERIOD_CHECK_EN enables the pps_missing tolerance/timeout check
module x4xx_pps_timekeeper
  import x4xx_pps_pkg::*;
#(
  parameter int TIME_W         = 64,
  parameter int PERIOD_W       = 32,
  parameter int NOMINAL_PERIOD = DEF_NOMINAL_PERIOD,
  parameter int PERIOD_TOL     = DEF_PERIOD_TOL
) (
  input  logic                radio_clk,
  input  logic                radio_rst_n,
  input  logic                pps_rc,
  input  logic                time_strobe,
  input  logic [TIME_W-1:0]   set_time_value,
  input  logic                set_time_now,
  input  logic                set_time_pps,
  input  logic                set_cancel,
  output logic [TIME_W-1:0]   time_now,
  output logic [TIME_W-1:0]   time_last_pps,
  output logic                pps_armed,
  output logic                pps_set_done,
  output logic [PERIOD_W-1:0] pps_period,
  output logic                pps_period_valid,
  output logic                pps_missing,
  input  logic                pps_missing_clr
);
  logic [TIME_W-1:0] time_q, time_d, last_q;
  pps_state_t state_q, state_d;
  logic armed_q, done_q, load_pps;
  always_comb begin
    load_pps = state_q == ST_ARMED && pps_rc && !set_cancel;
    time_d   = (set_time_now || load_pps) ? set_time_value : time_strobe ? time_q + 1'b1 : time_q;
    state_d  = state_q == ST_IDLE  ? (set_time_pps ? ST_ARMED : ST_IDLE) :
               state_q == ST_ARMED ? (set_cancel ? ST_IDLE : pps_rc ? ST_COMMIT : ST_ARMED) :
               ST_IDLE;
  end
  always_ff @(posedge radio_clk or negedge radio_rst_n)
    if (!radio_rst_n) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      time_q  <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= state_d == ST_ARMED;
      done_q  <= state_d == ST_COMMIT;
      time_q  <= time_d;
      if (pps_rc) last_q <= time_q;
    end
  assign time_now      = time_q;
  assign time_last_pps = last_q;
  assign pps_armed     = armed_q;
  assign pps_set_done  = done_q;
  x4xx_pps_period_meter #(
    .PERIOD_W      (PERIOD_W),
    .NOMINAL_PERIOD(NOMINAL_PERIOD),
    .PERIOD_TOL    (PERIOD_TOL)
  ) u_meter (
    .clk_i         (radio_clk),
    .rst_n_i       (radio_rst_n),
    .pps_i         (pps_rc),
    .missing_clr_i (pps_missing_clr),
    .period_o      (pps_period),
    .period_valid_o(pps_period_valid),
    .missing_o     (pps_missing)
  );
endmodule

// File: doc/x4xx_pps_timekeeper.md
Name: x4xx_pps_timekeeper

Overview:
Consumer end of the PPS chain: takes the single-cycle radio-clock PPS pulse and maintains the radio-domain 64-bit timekeeper.
- Supports "set time now" and "set time at next PPS" (arm/commit handshake).
- Latches time at each PPS edge.
- Measures the PPS period in radio clock cycles.
- Flags missing or early PPS.

Parameters:
TIME_W, 64, timekeeper and latched-time width
PERIOD_W, 32, PPS period counter width
NOMINAL_PERIOD, 250_000_000, expected radio_clk cycles per PPS
PERIOD_TOL, 1024, allowed ± deviation, in cycles, before a period counts as bad

Ports:
radio_clk  in  1  single clock
radio_rst_n  in  1  reset, asynchronous assert, active-low
pps_rc  in  1  one-cycle PPS pulse, radio_clk domain
time_strobe  in  1  time increments by 1 on cycles where this is high
set_time_value  in  TIME_W  value to load
set_time_now  in  1  pulse: load set_time_value immediately
set_time_pps  in  1  pulse: arm load at next pps_rc
set_cancel  in  1  pulse: disarm a pending PPS load
time_now  out  TIME_W  current time
time_last_pps  out  TIME_W  time_now value sampled on the last pps_rc
pps_armed  out  1  PPS load pending
pps_set_done  out  1  one-cycle pulse when the armed load commits
pps_period  out  PERIOD_W  cycles between the last two pps_rc pulses
pps_period_valid  out  1  at least two PPS seen since reset
pps_missing  out  1  sticky: period out of tolerance or PPS absent
pps_missing_clr  in  1  pulse: clear pps_missing

Behaviour:
- Reset (asynchronous, radio_rst_n=0): all outputs 0; FSM in IDLE; cycle counter 0; first-PPS flag cleared.
- time_now update priority, highest first, all registered with one-cycle latency:
  - set_time_now: time_now <= set_time_value.
  - FSM in ARMED and pps_rc: time_now <= set_time_value.
  - time_strobe: time_now <= time_now + 1.
  - Otherwise hold.
- time_now wraps from all-ones to 0 without error.
- pps_rc: time_last_pps <= time_now, using the pre-update value of the same cycle.
- FSM states: IDLE, ARMED, COMMIT.
  - IDLE: set_time_pps -> ARMED. set_time_pps is also honoured in the same cycle as set_time_now.
  - ARMED: pps_armed=1.
    - set_cancel -> IDLE with no load. set_cancel beats a simultaneous pps_rc.
    - pps_rc -> COMMIT, with the load applied on that edge.
    - set_time_pps while ARMED is ignored and stays armed.
    - set_time_now while ARMED loads immediately and stays armed; if pps_rc is in the same cycle, set_time_now's value wins, and the transition to COMMIT still occurs.
  - COMMIT: pps_set_done=1 for exactly one cycle -> IDLE.
  - Illegal state -> IDLE.
- Period measurement:
  - cycle_cnt increments every cycle and saturates at all-ones.
  - On pps_rc: if the first-PPS flag is set, pps_period <= cycle_cnt+1 and pps_period_valid <= 1. Then cycle_cnt <= 0 and the first-PPS flag is set.
  - pps_period_valid never drops except on reset.
- pps_missing: see Optional Feature.
  - pps_missing_clr clears it.
  - A set condition in the same cycle as the clear wins.

Optional Feature:
Macro X4XX_PPS_PERIOD_CHECK_EN.
- Defined:
  - pps_missing sets when, with pps_period_valid=1, a measured period falls outside NOMINAL_PERIOD±PERIOD_TOL.
  - pps_missing also sets when, after the first PPS, cycle_cnt reaches NOMINAL_PERIOD+PERIOD_TOL with no pps_rc. In that case it is asserted in the cycle after the count hits the limit, and is set once only.
- Undefined: pps_missing tied 0; pps_missing_clr ignored; no tolerance comparators synthesised.

Decomposition:
Shared package x4xx_pps_pkg:
- FSM state encoding: IDLE=0, ARMED=1, COMMIT=2.
- Default NOMINAL_PERIOD / PERIOD_TOL constants.

One natural sub-module, x4xx_pps_period_meter:
- Contains cycle_cnt, pps_period, the valid flag and the optional check.
- Keeps the top level to the timekeeper and the FSM.

Test Plan:
- Reset release, time_strobe=1 for 10 cycles -> time_now=10; all other outputs 0.
- set_time_value=64'h1000, set_time_pps pulse, pps_rc 20 cycles later with time_strobe held high:
  - pps_armed=1 until the PPS edge.
  - time_now=64'h1000 the cycle after pps_rc.
  - pps_set_done high for exactly one cycle.
  - time_last_pps = pre-load value.
- Armed, then set_cancel and pps_rc in the same cycle -> no load; FSM in IDLE; pps_set_done=0.
- time_now preset to 64'hFFFF_FFFF_FFFF_FFFF, one strobe -> 0.
- NOMINAL_PERIOD=1000, PERIOD_TOL=10, pps_rc every 1000 cycles -> after the 2nd pulse pps_period=1000, pps_period_valid=1, pps_missing=0.
- Macro defined, PPS stopped -> pps_missing=1 the cycle after cycle_cnt reaches 1010. Simultaneous pps_missing_clr and set condition -> stays 1. Clear alone -> 0.
